// File: rtl/wb_arb_2to1.sv
// Two-master Wishbone B3 arbiter: registered grant held for the owner's whole cycle,
// round-robin or fixed priority, with a stalled-strobe watchdog that terminates hung cycles.
module wb_arb_2to1 #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RR      = 1,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [2:0]      m0_cti_i,
  input  logic [1:0]      m0_bte_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic            m0_rty_o,
  output logic [DW-1:0]   m0_dat_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [2:0]      m1_cti_i,
  input  logic [1:0]      m1_bte_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            m1_rty_o,
  output logic [DW-1:0]   m1_dat_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [2:0]      s_cti_o,
  output logic [1:0]      s_bte_o,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic            s_rty_i,
  input  logic [DW-1:0]   s_dat_i,
  output logic [1:0]      grant_o,
  output logic            timeout_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_next;
  logic            r_last;       // 1 = m1 was the most recent owner
  logic            w_last_next;
  logic            w_own0;
  logic            w_own1;
  logic            w_cyc;
  logic            w_stb;
  logic            w_we;
  logic [AW-1:0]   w_adr;
  logic [DW/8-1:0] w_sel;
  logic [DW-1:0]   w_dat;
  logic [2:0]      w_cti;
  logic [1:0]      w_bte;
  logic            w_term;
  logic            w_expire;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_last  <= w_last_next;
    end
  end

  // Ownership only changes through IDLE, so a grant never switches inside a cycle.
  always_comb begin
    w_state_next = r_state;
    w_last_next  = r_last;
    case (r_state)
      S_IDLE: begin
        if (m0_cyc_i && m1_cyc_i)
          w_state_next = ((RR != 0) && r_last) ? S_OWN0 : S_OWN1;
        else if (m0_cyc_i)
          w_state_next = S_OWN0;
        else if (m1_cyc_i)
          w_state_next = S_OWN1;
      end
      S_OWN0: begin
        if (!m0_cyc_i) begin
          w_state_next = S_IDLE;
          w_last_next  = 1'b0;
        end
      end
      S_OWN1: begin
        if (!m1_cyc_i) begin
          w_state_next = S_IDLE;
          w_last_next  = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_own0 = (r_state == S_OWN0);
  assign w_own1 = (r_state == S_OWN1);

  always_comb begin
    w_cyc = 1'b0;
    w_stb = 1'b0;
    w_we  = 1'b0;
    w_adr = '0;
    w_sel = '0;
    w_dat = '0;
    w_cti = '0;
    w_bte = '0;
    if (w_own0) begin
      w_cyc = m0_cyc_i;
      w_stb = m0_stb_i;
      w_we  = m0_we_i;
      w_adr = m0_adr_i;
      w_sel = m0_sel_i;
      w_dat = m0_dat_i;
      w_cti = m0_cti_i;
      w_bte = m0_bte_i;
    end else if (w_own1) begin
      w_cyc = m1_cyc_i;
      w_stb = m1_stb_i;
      w_we  = m1_we_i;
      w_adr = m1_adr_i;
      w_sel = m1_sel_i;
      w_dat = m1_dat_i;
      w_cti = m1_cti_i;
      w_bte = m1_bte_i;
    end
  end

  assign w_term = s_ack_i | s_err_i | s_rty_i;

  generate
    if (TIMEOUT > 0) begin : g_wdog
      localparam int CW = $clog2(TIMEOUT + 1);
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
      logic [CW-1:0] r_cnt;

      // A real termination in the expiry cycle takes precedence over the watchdog.
      assign w_expire = w_stb && !w_term && (r_cnt == LIMIT);

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
          r_cnt <= '0;
        else if ((r_state == S_IDLE) || w_term || !w_stb || w_expire)
          r_cnt <= '0;
        else
          r_cnt <= r_cnt + CW'(1);
      end
    end else begin : g_no_wdog
      assign w_expire = 1'b0;
    end
  endgenerate

  assign s_cyc_o = w_cyc;
  assign s_stb_o = w_stb & ~w_expire;
  assign s_we_o  = w_we;
  assign s_adr_o = w_adr;
  assign s_sel_o = w_sel;
  assign s_dat_o = w_dat;
  assign s_cti_o = w_cti;
  assign s_bte_o = w_bte;

  assign m0_ack_o = w_own0 & m0_stb_i & s_ack_i;
  assign m0_err_o = w_own0 & m0_stb_i & (s_err_i | w_expire);
  assign m0_rty_o = w_own0 & m0_stb_i & s_rty_i;
  assign m1_ack_o = w_own1 & m1_stb_i & s_ack_i;
  assign m1_err_o = w_own1 & m1_stb_i & (s_err_i | w_expire);
  assign m1_rty_o = w_own1 & m1_stb_i & s_rty_i;

  assign m0_dat_o  = s_dat_i;
  assign m1_dat_o  = s_dat_i;
  assign grant_o   = {w_own1, w_own0};
  assign timeout_o = w_expire;

endmodule

// File: tb/tb_wb_arb_2to1.sv
// Bench for wb_arb_2to1: scoreboarded reads against a registered-ack slave model,
// plus arbitration, burst lock, watchdog, fixed-priority and reset scenarios.
module tb_wb_arb_2to1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic [2:0]  m0_cti, m1_cti;
  logic [1:0]  m0_bte, m1_bte;
  logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o;
  logic        s_ack, s_err, s_rty;
  logic [31:0] s_dat;
  logic [1:0]  grant_o;
  logic        timeout_o;

  // slave model: registered ack, read data = ~address
  logic r_sack, slave_en, tb_ack;
  always @(posedge clk or posedge rst)
    if (rst) r_sack <= 1'b0;
    else     r_sack <= s_stb_o && !r_sack && slave_en;
  assign s_ack = r_sack | tb_ack;
  assign s_err = 1'b0;
  assign s_rty = 1'b0;
  assign s_dat = ~s_adr_o;

  wb_arb_2to1 #(.AW(32), .DW(32), .RR(1), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_sel_i(m0_sel), .m0_dat_i(m0_dat), .m0_cti_i(m0_cti), .m0_bte_i(m0_bte),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_sel_i(m1_sel), .m1_dat_i(m1_dat), .m1_cti_i(m1_cti), .m1_bte_i(m1_bte),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty), .s_dat_i(s_dat),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  // second instance: fixed priority, watchdog off
  logic        d2_m0_cyc, d2_m1_cyc;
  logic        d2_m0_ack, d2_m0_err, d2_m0_rty, d2_m1_ack, d2_m1_err, d2_m1_rty;
  logic [31:0] d2_m0_dat_o, d2_m1_dat_o, d2_s_adr, d2_s_dat_o;
  logic        d2_s_cyc, d2_s_stb, d2_s_we;
  logic [3:0]  d2_s_sel;
  logic [2:0]  d2_s_cti;
  logic [1:0]  d2_s_bte, d2_grant;
  logic        d2_timeout, r_sack2;
  always @(posedge clk or posedge rst)
    if (rst) r_sack2 <= 1'b0;
    else     r_sack2 <= d2_s_stb && !r_sack2;

  wb_arb_2to1 #(.AW(32), .DW(32), .RR(0), .TIMEOUT(0)) dut2 (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(d2_m0_cyc), .m0_stb_i(d2_m0_cyc), .m0_we_i(1'b0), .m0_adr_i(32'h100),
    .m0_sel_i(4'hF), .m0_dat_i(32'h0), .m0_cti_i(3'b000), .m0_bte_i(2'b00),
    .m0_ack_o(d2_m0_ack), .m0_err_o(d2_m0_err), .m0_rty_o(d2_m0_rty), .m0_dat_o(d2_m0_dat_o),
    .m1_cyc_i(d2_m1_cyc), .m1_stb_i(d2_m1_cyc), .m1_we_i(1'b0), .m1_adr_i(32'h200),
    .m1_sel_i(4'hF), .m1_dat_i(32'h0), .m1_cti_i(3'b000), .m1_bte_i(2'b00),
    .m1_ack_o(d2_m1_ack), .m1_err_o(d2_m1_err), .m1_rty_o(d2_m1_rty), .m1_dat_o(d2_m1_dat_o),
    .s_cyc_o(d2_s_cyc), .s_stb_o(d2_s_stb), .s_we_o(d2_s_we), .s_adr_o(d2_s_adr),
    .s_sel_o(d2_s_sel), .s_dat_o(d2_s_dat_o), .s_cti_o(d2_s_cti), .s_bte_o(d2_s_bte),
    .s_ack_i(r_sack2), .s_err_i(1'b0), .s_rty_i(1'b0), .s_dat_i(32'h0),
    .grant_o(d2_grant), .timeout_o(d2_timeout)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end else
      $display("ok   %s = %0h", tag, got);
  endtask

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  int ack_cnt0 = 0, ack_cnt1 = 0, m1cnt_at_m0_ack = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (m0_ack_o) begin
        ack_cnt0++;
        m1cnt_at_m0_ack = ack_cnt1;
        if (exp_q0.size() == 0) check("sb0_underflow", 1, 0);
        else check("m0_rdata", m0_dat_o, exp_q0.pop_front());
        check("m0_ack_grant", grant_o, 2'b01);
        check("m0_ack_excl", m1_ack_o, 0);
      end
      if (m1_ack_o) begin
        ack_cnt1++;
        if (exp_q1.size() == 0) check("sb1_underflow", 1, 0);
        else check("m1_rdata", m1_dat_o, exp_q1.pop_front());
        check("m1_ack_grant", grant_o, 2'b10);
        check("m1_ack_excl", m0_ack_o, 0);
      end
    end
  end

  task automatic drive(input int id, input logic cyc, input logic stb,
                       input logic [31:0] adr, input logic [2:0] cti);
    if (id == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_adr = adr; m0_cti = cti;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_adr = adr; m1_cti = cti;
    end
  endtask

  task automatic do_read(input int id, input logic [31:0] base, input int beats);
    logic [31:0] a;
    logic [2:0]  cti;
    bit          got;
    a = base;
    @(posedge clk); #1;
    for (int b = 0; b < beats; b++) begin
      cti = (beats == 1) ? 3'b000 : ((b == beats - 1) ? 3'b111 : 3'b010);
      drive(id, 1'b1, 1'b1, a, cti);
      if (id == 0) exp_q0.push_back(~a); else exp_q1.push_back(~a);
      got = 1'b0;
      for (int t = 0; t < 60 && !got; t++) begin
        @(negedge clk);
        got = (id == 0) ? m0_ack_o : m1_ack_o;
      end
      if (!got) begin
        check("ack_wait_expired", 0, 1);
        if (id == 0) void'(exp_q0.pop_back()); else void'(exp_q1.pop_back());
      end else
        check("beat_cti", s_cti_o, cti);
      @(posedge clk); #1;
      a += 32'd4;
    end
    drive(id, 1'b0, 1'b0, 32'h0, 3'b000);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 3'b000);
    drive(1, 1'b0, 1'b0, 32'h0, 3'b000);
    d2_m0_cyc = 1'b0; d2_m1_cyc = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit");
    $fatal(1, "time limit");
  end

  initial begin
    int idle, base1, arbs, d2m0acks;
    logic [1:0] prev_g;
    bit drop_pend, restore;
    m0_we = 0; m1_we = 0; m0_sel = 4'hF; m1_sel = 4'hF;
    m0_dat = 0; m1_dat = 0; m0_bte = 0; m1_bte = 0;
    slave_en = 1'b1; tb_ack = 1'b0;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 3'b000);
    drive(1, 1'b0, 1'b0, 32'h0, 3'b000);
    d2_m0_cyc = 1'b0; d2_m1_cyc = 1'b0;
    @(negedge clk);
    check("rst_grant", grant_o, 2'b00);
    check("rst_s_cyc", s_cyc_o, 0);
    check("rst_s_stb", s_stb_o, 0);
    check("rst_timeout", timeout_o, 0);
    apply_reset();

    // single m0 read, one-cycle arbitration latency
    fork
      do_read(0, 32'h2152_4110, 1);
      begin
        @(posedge clk);
        @(negedge clk);
        check("t1_idle_cycle_s_cyc", s_cyc_o, 0);
        @(negedge clk);
        check("t1_s_cyc", s_cyc_o, 1);
        check("t1_grant", grant_o, 2'b01);
        check("t1_s_adr", s_adr_o, 32'h2152_4110);
      end
    join
    check("t1_m0_acks", ack_cnt0, 1);

    // simultaneous requests, round-robin from last=m1
    apply_reset();
    fork
      do_read(0, 32'h0000_1000, 1);
      do_read(1, 32'h0000_2000, 1);
      begin
        for (int t = 0; t < 30 && grant_o == 2'b00; t++) @(negedge clk);
        check("t2_first_grant", grant_o, 2'b01);
        for (int t = 0; t < 30 && grant_o != 2'b00; t++) @(negedge clk);
        idle = 0;
        for (int t = 0; t < 30 && grant_o == 2'b00; t++) begin
          idle++;
          @(negedge clk);
        end
        check("t2_second_grant", grant_o, 2'b10);
        check("t2_handoff_idle", idle, 1);
      end
    join

    // m1 burst holds the grant while m0 waits
    base1 = ack_cnt1;
    fork
      do_read(1, 32'h0000_3000, 4);
      begin
        repeat (3) @(posedge clk);
        do_read(0, 32'h0000_4000, 1);
      end
    join
    check("t3_burst_before_m0", m1cnt_at_m0_ack - base1, 4);

    // watchdog: round 0 never acks, round 1 acks on the expiry cycle
    slave_en = 1'b0;
    for (int mode = 0; mode < 2; mode++) begin
      repeat (2) @(posedge clk);
      #1 drive(0, 1'b1, 1'b1, 32'h0000_5000, 3'b000);
      if (mode == 1) exp_q0.push_back(~32'h0000_5000);
      for (int k = 1; k <= 9; k++) begin
        @(posedge clk); #1;
        tb_ack = (mode == 1 && k == 8);
        @(negedge clk);
        if (k == 8) begin
          check(mode == 0 ? "t4_err_c8" : "t4_ack_no_err", m0_err_o, mode == 0);
          check(mode == 0 ? "t4_tmo_c8" : "t4_ack_no_tmo", timeout_o, mode == 0);
          check(mode == 0 ? "t4_stb_gated" : "t4_stb_kept", s_stb_o, mode != 0);
          check("t4_m1_err", m1_err_o, 0);
        end else if (k == 7 || k == 9) begin
          check("t4_no_err", m0_err_o, 0);
          check("t4_no_tmo", timeout_o, 0);
        end
      end
      @(posedge clk); #1;
      tb_ack = 1'b0;
      drive(0, 1'b0, 1'b0, 32'h0, 3'b000);
    end
    slave_en = 1'b1;
    repeat (3) @(posedge clk);

    // fixed priority: m1 wins every arbitration
    #1 d2_m0_cyc = 1'b1; d2_m1_cyc = 1'b1;
    prev_g = 2'b00; arbs = 0; d2m0acks = 0; drop_pend = 0; restore = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (drop_pend) begin d2_m1_cyc = 1'b0; drop_pend = 0; restore = 1; end
      else if (restore) begin d2_m1_cyc = 1'b1; restore = 0; end
      @(negedge clk);
      if (d2_grant != 2'b00 && prev_g == 2'b00) begin
        arbs++;
        check("t5_fixed_grant", d2_grant, 2'b10);
      end
      if (d2_m1_ack) drop_pend = 1;
      if (d2_m0_ack) d2m0acks++;
      prev_g = d2_grant;
    end
    check("t5_arbitrations", arbs >= 5, 1);
    check("t5_m0_starved", d2m0acks, 0);
    @(posedge clk); #1 d2_m0_cyc = 1'b0; d2_m1_cyc = 1'b0;

    // asynchronous reset in the middle of an m1 burst
    slave_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 drive(1, 1'b1, 1'b1, 32'h0000_6000, 3'b010);
    repeat (3) @(negedge clk);
    check("t6_pre_grant", grant_o, 2'b10);
    check("t6_pre_cyc", s_cyc_o, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_cyc", s_cyc_o, 0);
    check("t6_rst_grant", grant_o, 2'b00);
    drive(1, 1'b0, 1'b0, 32'h0, 3'b000);
    @(posedge clk); #1 rst = 1'b0;
    slave_en = 1'b1;
    do_read(0, 32'h0000_7000, 1);
    do_read(1, 32'h0000_8000, 1);

    repeat (3) @(posedge clk);
    check("sb_drain", exp_q0.size() + exp_q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
